// File: rtl/bf_io_pkg.sv
// bf_io_pkg: shared types and defaults for the Brainfuck I/O port.
// The optional echo feature is enabled by defining BF_IO_ECHO_EN.
package bf_io_pkg;

  // Default number of entries per FIFO (power of 2, at least 2).
  localparam int DEFAULT_DEPTH = 8;

  // in_byte value before any byte is delivered.
  localparam logic [7:0] DEFAULT_EOF_BYTE = 8'h00;

  // States of the ',' input handshake.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } in_state_t;

endpackage

// File: rtl/bf_io_fifo.sv
// bf_io_fifo: synchronous DEPTH x 8 FIFO with full/empty/count.
// The head entry is read directly from the register array, so a pushed
// byte is visible at the head the cycle after the push.
// A push while full is accepted only if a pop happens in the same cycle.
module bf_io_fifo
  import bf_io_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem_reg[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage array: written on accepted pushes, never reset.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        count_reg <= count_reg - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/bf_io_port.sv
// bf_io_port: '.' and ',' I/O for a Brainfuck core, buffered by two FIFOs
// toward a host byte stream. Define BF_IO_ECHO_EN to echo every delivered
// input byte back into the output FIFO.
module bf_io_port
  import bf_io_pkg::*;
#(
  parameter int         DEPTH    = DEFAULT_DEPTH,
  parameter logic [7:0] EOF_BYTE = DEFAULT_EOF_BYTE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       out_strobe,
  input  logic [7:0] out_byte,
  output logic       out_busy,
  output logic       out_overflow,
  input  logic       in_req,
  output logic [7:0] in_byte,
  output logic       in_ack,
  output logic [7:0] host_tx_data,
  output logic       host_tx_valid,
  input  logic       host_tx_ready,
  input  logic [7:0] host_rx_data,
  input  logic       host_rx_valid,
  output logic       host_rx_ready
);

  localparam int AW = $clog2(DEPTH);

  in_state_t   state_reg;
  logic        in_ack_reg;
  logic [7:0]  in_byte_reg;
  logic        overflow_reg;

  logic        out_push;
  logic [7:0]  out_push_data;
  logic        out_pop;
  logic        out_full;
  logic        out_empty;
  logic [AW:0] out_count;

  logic        in_push;
  logic        in_pop;
  logic [7:0]  in_head;
  logic        in_full;
  logic        in_empty;
  logic [AW:0] in_count;

  logic        wait_ready;
  logic        unused_counts;

  // Occupancy counts are not needed at this level.
  assign unused_counts = ^{out_count, in_count};

  assign out_pop = !out_empty && host_tx_ready;
  assign in_push = host_rx_valid && !in_full;
  assign in_pop  = (state_reg == WAIT) && in_req && wait_ready;

`ifdef BF_IO_ECHO_EN
  // Echo shares the output FIFO, so delivery waits for room and for a
  // cycle without a processor strobe; the echo push lands with the pop.
  assign wait_ready    = !in_empty && !out_full && !out_strobe;
  assign out_push      = out_strobe || in_pop;
  assign out_push_data = in_pop ? in_head : out_byte;
`else
  assign wait_ready    = !in_empty;
  assign out_push      = out_strobe;
  assign out_push_data = out_byte;
`endif

  bf_io_fifo #(.DEPTH(DEPTH)) u_out_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (out_push),
    .push_data (out_push_data),
    .pop       (out_pop),
    .head      (host_tx_data),
    .full      (out_full),
    .empty     (out_empty),
    .count     (out_count)
  );

  bf_io_fifo #(.DEPTH(DEPTH)) u_in_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (in_push),
    .push_data (host_rx_data),
    .pop       (in_pop),
    .head      (in_head),
    .full      (in_full),
    .empty     (in_empty),
    .count     (in_count)
  );

  // Sticky flag: a strobe was dropped because the output FIFO had no room.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (out_strobe && out_full && !out_pop) begin
      overflow_reg <= 1'b1;
    end
  end

  // Input handshake: wait for data, latch it, pulse in_ack for one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      in_ack_reg  <= 1'b0;
      in_byte_reg <= EOF_BYTE;
    end else begin
      case (state_reg)
        IDLE: begin
          in_ack_reg <= 1'b0;
          if (in_req) begin
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (!in_req) begin
            state_reg <= IDLE;
          end else if (wait_ready) begin
            in_byte_reg <= in_head;
            in_ack_reg  <= 1'b1;
            state_reg   <= ACK;
          end
        end
        ACK: begin
          in_ack_reg <= 1'b0;
          state_reg  <= IDLE;
        end
        default: begin
          in_ack_reg <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

  assign out_busy      = out_full;
  assign out_overflow  = overflow_reg;
  assign host_tx_valid = !out_empty;
  assign host_rx_ready = !in_full;
  assign in_ack        = in_ack_reg;
  assign in_byte       = in_byte_reg;

endmodule

// File: tb/tb_bf_io_port.sv
// tb_bf_io_port: directed self-checking bench for bf_io_port (DEPTH=8).
module tb_bf_io_port;

  logic       clock;
  logic       reset;
  logic       out_strobe;
  logic [7:0] out_byte;
  logic       out_busy;
  logic       out_overflow;
  logic       in_req;
  logic [7:0] in_byte;
  logic       in_ack;
  logic [7:0] host_tx_data;
  logic       host_tx_valid;
  logic       host_tx_ready;
  logic [7:0] host_rx_data;
  logic       host_rx_valid;
  logic       host_rx_ready;

  int tests;
  int fails;

  bf_io_port dut (
    .clock         (clock),
    .reset         (reset),
    .out_strobe    (out_strobe),
    .out_byte      (out_byte),
    .out_busy      (out_busy),
    .out_overflow  (out_overflow),
    .in_req        (in_req),
    .in_byte       (in_byte),
    .in_ack        (in_ack),
    .host_tx_data  (host_tx_data),
    .host_tx_valid (host_tx_valid),
    .host_tx_ready (host_tx_ready),
    .host_rx_data  (host_rx_data),
    .host_rx_valid (host_rx_valid),
    .host_rx_ready (host_rx_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    out_strobe = 1'b0;
    out_byte = 8'h00;
    in_req = 1'b0;
    host_tx_ready = 1'b0;
    host_rx_data = 8'h00;
    host_rx_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Reset state
    check("rst_tx_valid", host_tx_valid, 0);
    check("rst_busy", out_busy, 0);
    check("rst_overflow", out_overflow, 0);
    check("rst_ack", in_ack, 0);
    check("rst_rx_ready", host_rx_ready, 1);
    check("rst_in_byte", in_byte, 8'h00);
    reset = 1'b0;
    tick();

    // Two strobes, in-order delivery to the host
    out_strobe = 1'b1; out_byte = 8'h48;
    tick();
    check("tx_first_valid", host_tx_valid, 1);
    check("tx_first_data", host_tx_data, 8'h48);
    host_tx_ready = 1'b1; out_byte = 8'h69;
    tick();
    out_strobe = 1'b0;
    check("tx_second_data", host_tx_data, 8'h69);
    check("tx_second_valid", host_tx_valid, 1);
    tick();
    check("tx_drained", host_tx_valid, 0);

    // Full FIFO: simultaneous pop and strobe keeps count, no overflow
    host_tx_ready = 1'b0; out_strobe = 1'b1;
    for (int i = 0; i < 8; i++) begin
      out_byte = 8'hA0 + 8'(i);
      tick();
    end
    check("simul_full_before", out_busy, 1);
    out_byte = 8'hAF; host_tx_ready = 1'b1;
    tick();
    out_strobe = 1'b0; host_tx_ready = 1'b0;
    check("simul_busy", out_busy, 1);
    check("simul_no_overflow", out_overflow, 0);
    check("simul_head", host_tx_data, 8'hA1);
    host_tx_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check("simul_drain", host_tx_data, 8'hA0 + 8'(i));
      tick();
    end
    check("simul_drain_last", host_tx_data, 8'hAF);
    tick();
    check("simul_empty", host_tx_valid, 0);

    // Nine strobes into an 8-deep FIFO with no host reads
    host_tx_ready = 1'b0; out_strobe = 1'b1;
    for (int i = 0; i < 9; i++) begin
      out_byte = 8'h10 + 8'(i);
      tick();
      if (i == 6) check("ovf_busy_7th", out_busy, 0);
      if (i == 7) begin
        check("ovf_busy_8th", out_busy, 1);
        check("ovf_not_yet", out_overflow, 0);
      end
    end
    out_strobe = 1'b0;
    check("ovf_set", out_overflow, 1);
    check("ovf_busy_9th", out_busy, 1);
    host_tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain", host_tx_data, 8'h10 + 8'(i));
      tick();
    end
    check("ovf_drain_empty", host_tx_valid, 0);

    // Basic ',' with data already present: ack two cycles after in_req
    host_rx_valid = 1'b1; host_rx_data = 8'h41;
    tick();
    host_rx_valid = 1'b0;
    in_req = 1'b1;
    tick();
    check("rd_ack_early", in_ack, 0);
    tick();
    check("rd_ack", in_ack, 1);
    check("rd_byte", in_byte, 8'h41);
    in_req = 1'b0;
    tick();
    check("rd_ack_single", in_ack, 0);
    check("rd_byte_hold", in_byte, 8'h41);

    // in_req withdrawn in WAIT: no pop, byte still available afterwards
    host_rx_valid = 1'b1; host_rx_data = 8'h55;
    tick();
    host_rx_valid = 1'b0;
    tick();
    tick();
    check("nreq_no_ack", in_ack, 0);
    in_req = 1'b1;
    tick();
    in_req = 1'b0;
    tick();
    check("abort_no_ack", in_ack, 0);
    tick();
    in_req = 1'b1;
    tick();
    tick();
    check("abort_ack", in_ack, 1);
    check("abort_byte", in_byte, 8'h55);
    in_req = 1'b0;
    tick();

    // Empty FIFO: WAIT holds for 20 cycles, then data arrives
    in_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("empty_wait_no_ack", in_ack, 0);
    end
    host_rx_valid = 1'b1; host_rx_data = 8'h7A;
    tick();
    host_rx_valid = 1'b0;
    check("late_no_ack_yet", in_ack, 0);
    tick();
    check("late_ack", in_ack, 1);
    check("late_byte", in_byte, 8'h7A);
    in_req = 1'b0;
    tick();
    check("late_ack_single", in_ack, 0);

    // Reset mid-WAIT with three bytes queued and one output byte pending
    host_tx_ready = 1'b0;
    out_strobe = 1'b1; out_byte = 8'h33;
    host_rx_valid = 1'b1; host_rx_data = 8'h01;
    tick();
    out_strobe = 1'b0; host_rx_data = 8'h02;
    tick();
    host_rx_data = 8'h03;
    tick();
    host_rx_valid = 1'b0;
    check("mid_tx_valid", host_tx_valid, 1);
    in_req = 1'b1;
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_tx_valid", host_tx_valid, 0);
    check("mid_rst_busy", out_busy, 0);
    check("mid_rst_ack", in_ack, 0);
    check("mid_rst_rx_ready", host_rx_ready, 1);
    check("mid_rst_in_byte", in_byte, 8'h00);
    in_req = 1'b0;
    #1;
    reset = 1'b0;
    tick();
    in_req = 1'b1;
    tick();
    tick();
    tick();
    check("mid_rst_in_empty", in_ack, 0);
    in_req = 1'b0;
    tick();

    // Input FIFO fills: host_rx_ready drops after 8 bytes
    host_rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      host_rx_data = 8'h80 + 8'(i);
      tick();
      if (i == 6) check("rx_ready_7th", host_rx_ready, 1);
    end
    host_rx_valid = 1'b0;
    check("rx_full", host_rx_ready, 0);
    in_req = 1'b1;
    tick();
    tick();
    check("rx_full_ack", in_ack, 1);
    check("rx_full_byte", in_byte, 8'h80);
    check("rx_ready_after_pop", host_rx_ready, 1);
    in_req = 1'b0;
    tick();

`ifdef BF_IO_ECHO_EN
    // Echo: delivery waits for output room, then the byte reaches the host
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    host_tx_ready = 1'b0; out_strobe = 1'b1;
    for (int i = 0; i < 8; i++) begin
      out_byte = 8'hC0 + 8'(i);
      tick();
    end
    out_strobe = 1'b0;
    check("echo_out_full", out_busy, 1);
    host_rx_valid = 1'b1; host_rx_data = 8'h2C;
    tick();
    host_rx_valid = 1'b0;
    in_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("echo_blocked", in_ack, 0);
    end
    host_tx_ready = 1'b1;
    tick();
    host_tx_ready = 1'b0;
    check("echo_room", out_busy, 0);
    check("echo_not_yet", in_ack, 0);
    tick();
    check("echo_ack", in_ack, 1);
    check("echo_byte", in_byte, 8'h2C);
    check("echo_refilled", out_busy, 1);
    in_req = 1'b0;
    host_tx_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check("echo_drain", host_tx_data, 8'hC0 + 8'(i));
      tick();
    end
    check("echo_tx_byte", host_tx_data, 8'h2C);
    tick();
    check("echo_tx_empty", host_tx_valid, 0);
    check("echo_no_overflow", out_overflow, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
